// File: rtl/alu_seq_ctrl_pkg.sv
// Shared definitions for the ALU sequencer: command op codes and the
// controller state encoding.
package alu_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,  // unsigned shift-add
    OP_DIV = 2'b11   // unsigned restoring
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage : alu_seq_ctrl_pkg

// File: rtl/alu_seq_ctrl_alu.sv
// Shared DW-bit add/sub ALU. Purely combinational; lives beside the
// sequencer at top level and is driven through the sequencer's alu_* ports.
// Ports:
//   a, b  operands
//   sub   1 = a - b, 0 = a + b
//   sum   DW-bit result
//   cout  add: carry out; subtract: borrow (a < b unsigned)
//   ovf   signed overflow of the selected operation
//   zero  sum == 0
module alu_seq_ctrl_alu #(
  parameter int DW = 8
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          sub,
  output logic [DW-1:0] sum,
  output logic          cout,
  output logic          ovf,
  output logic          zero
);

  logic [DW:0] full;

  // The 9th bit of a zero-extended subtraction wraps to 1 exactly when a < b,
  // so the same bit serves as carry (add) and borrow (subtract).
  assign full = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
  assign sum  = full[DW-1:0];
  assign cout = full[DW];
  assign zero = (sum == '0);

  // Overflow: add with like signs, or subtract with unlike signs, whose
  // result sign differs from a.
  assign ovf  = ((a[DW-1] ^ b[DW-1]) == sub) && (sum[DW-1] != a[DW-1]);

endmodule : alu_seq_ctrl_alu

// File: rtl/alu_seq_ctrl.sv
// Sequencer owning the shared add/sub ALU. Runs single-cycle ADD/SUB and
// DW-step shift-add MUL / restoring DIV on it.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid/in_ready          command handshake; in_op/in_a/in_b command
//   out_valid/out_ready        result handshake; result held until accepted
//   out_res                    ADD/SUB {0,sum}; MUL product; DIV {rem,quot}
//   out_cout/ovf/zero/err      result flags
//   busy                       controller not idle
//   alu_a/alu_b/alu_sub        drive the sibling ALU (0 outside EXEC)
//   alu_sum/cout/ovf/zero      ALU results
module alu_seq_ctrl
  import alu_seq_ctrl_pkg::*;
#(
  parameter int            DW      = 8,
  parameter logic [DW-1:0] DZ_QUOT = 8'hFF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic [DW-1:0]   in_a,
  input  logic [DW-1:0]   in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*DW-1:0] out_res,
  output logic            out_cout,
  output logic            out_ovf,
  output logic            out_zero,
  output logic            out_err,
  output logic            busy,
  output logic [DW-1:0]   alu_a,
  output logic [DW-1:0]   alu_b,
  output logic            alu_sub,
  input  logic [DW-1:0]   alu_sum,
  input  logic            alu_cout,
  input  logic            alu_ovf,
  input  logic            alu_zero
);

  localparam int CW = $clog2(DW);

  state_e        state_q, state_d;
  op_e           op_q, op_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [DW-1:0] r_q, r_d;     // high half: partial product / remainder
  logic [DW-1:0] q_q, q_d;     // low half: multiplier->product / dividend->quotient
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;
  logic          zero_q, zero_d;
  logic          err_q, err_d;
  logic [DW:0]   t;            // DIV shifted partial remainder, one bit wider than R
  logic          last_step;

  always_ff @(posedge clk) begin
    // NOTE: reset is sampled inside the clocked branch (synchronous); every
    // register is cleared so an op aborted by reset leaves no stale result.
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    r_d       = r_q;
    q_d       = q_q;
    cnt_d     = cnt_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    zero_d    = zero_q;
    err_d     = err_q;
    alu_a     = '0;
    alu_b     = '0;
    alu_sub   = 1'b0;
    t         = {r_q, q_q[DW-1]};
    last_step = (cnt_q == CW'(DW - 1));

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d   = op_e'(in_op);
          a_d    = in_a;
          b_d    = in_b;
          r_d    = '0;
          // MUL shifts the multiplier (b) out of Q while adding a into R;
          // DIV shifts the dividend (a) out of Q.
          q_d    = (in_op == OP_MUL) ? in_b : in_a;
          cnt_d  = '0;
          cout_d = 1'b0;
          ovf_d  = 1'b0;
          zero_d = 1'b0;
          err_d  = 1'b0;
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        unique case (op_q)
          OP_ADD, OP_SUB: begin
            alu_a   = a_q;
            alu_b   = b_q;
            alu_sub = op_q[0];
            r_d     = '0;
            q_d     = alu_sum;
            cout_d  = alu_cout;
            ovf_d   = alu_ovf;
            zero_d  = alu_zero;
            state_d = ST_DONE;
          end

          OP_MUL: begin
            alu_a = r_q;
            alu_b = a_q;
            // {R,Q} shifts right one place; the ALU carry is the bit that
            // re-enters at the top when the multiplier bit is set.
            if (q_q[0]) begin
              r_d = {alu_cout, alu_sum[DW-1:1]};
              q_d = {alu_sum[0], q_q[DW-1:1]};
            end else begin
              r_d = {1'b0, r_q[DW-1:1]};
              q_d = {r_q[0], q_q[DW-1:1]};
            end
            cnt_d = cnt_q + CW'(1);
            if (last_step) begin
              cout_d  = |r_d;
              zero_d  = ({r_d, q_d} == '0);
              state_d = ST_DONE;
            end
          end

          OP_DIV: begin
            if (b_q == '0) begin
              r_d     = a_q;
              q_d     = DZ_QUOT;
              err_d   = 1'b1;
              zero_d  = (DZ_QUOT == '0);
              state_d = ST_DONE;
            end else begin
              alu_a   = t[DW-1:0];
              alu_b   = b_q;
              alu_sub = 1'b1;
              // t fits the divisor if its hidden 9th bit is set or the
              // subtraction did not borrow.
              if (t[DW] || !alu_cout) begin
                r_d = alu_sum;
                q_d = {q_q[DW-2:0], 1'b1};
              end else begin
                r_d = t[DW-1:0];
                q_d = {q_q[DW-2:0], 1'b0};
              end
              cnt_d = cnt_q + CW'(1);
              if (last_step) begin
                zero_d  = (q_d == '0);
                state_d = ST_DONE;
              end
            end
          end

          default: state_d = ST_DONE;
        endcase
      end

      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = (state_q == ST_DONE);

  // Intermediate {R,Q} contents are not a result; expose them only in DONE.
  assign out_res   = out_valid ? {r_q, q_q} : '0;
  assign out_cout  = out_valid & cout_q;
  assign out_ovf   = out_valid & ovf_q;
  assign out_zero  = out_valid & zero_q;
  assign out_err   = out_valid & err_q;

endmodule : alu_seq_ctrl

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl with its sibling ALU.
// Latency is counted as the first clock edge after the accept edge T at which
// out_valid is high (sampled on the preceding falling edge).
module tb_alu_seq_ctrl;
  import alu_seq_ctrl_pkg::*;

  localparam int DW = 8;

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] res;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic        err;
    int          lat;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_res;
  logic        out_cout;
  logic        out_ovf;
  logic        out_zero;
  logic        out_err;
  logic        busy;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic        alu_sub;
  logic [7:0]  alu_sum;
  logic        alu_cout;
  logic        alu_ovf;
  logic        alu_zero;

  int checks   = 0;
  int failures = 0;

  alu_seq_ctrl #(.DW(DW), .DZ_QUOT(8'hFF)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .out_zero  (out_zero),
    .out_err   (out_err),
    .busy      (busy),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sub   (alu_sub),
    .alu_sum   (alu_sum),
    .alu_cout  (alu_cout),
    .alu_ovf   (alu_ovf),
    .alu_zero  (alu_zero)
  );

  alu_seq_ctrl_alu #(.DW(DW)) u_alu (
    .a    (alu_a),
    .b    (alu_b),
    .sub  (alu_sub),
    .sum  (alu_sum),
    .cout (alu_cout),
    .ovf  (alu_ovf),
    .zero (alu_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain arithmetic on the operands, independent of the
  // shift/subtract iteration the controller performs.
  function automatic vec_t model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    vec_t        v;
    int          s;
    logic [8:0]  w;
    logic [15:0] p;
    v.op = op; v.a = a; v.b = b;
    v.res = '0; v.cout = 1'b0; v.ovf = 1'b0; v.zero = 1'b0; v.err = 1'b0; v.lat = 2;
    case (op)
      2'd0: begin
        w = {1'b0, a} + {1'b0, b};
        s = int'($signed(a)) + int'($signed(b));
        v.res = {8'h00, w[7:0]};
        v.cout = w[8];
        v.ovf = (s > 127) || (s < -128);
        v.zero = (w[7:0] == 8'h00);
      end
      2'd1: begin
        w = {1'b0, a} - {1'b0, b};
        s = int'($signed(a)) - int'($signed(b));
        v.res = {8'h00, w[7:0]};
        v.cout = (a < b);
        v.ovf = (s > 127) || (s < -128);
        v.zero = (a == b);
      end
      2'd2: begin
        p = 16'(a) * 16'(b);
        v.res = p;
        v.cout = (p > 16'd255);
        v.zero = (p == 16'd0);
        v.lat = 9;
      end
      default: begin
        if (b == 8'h00) begin
          v.res = {a, 8'hFF};
          v.err = 1'b1;
        end else begin
          v.res = {a % b, a / b};
          v.zero = ((a / b) == 0);
          v.lat = 9;
        end
      end
    endcase
    return v;
  endfunction

  // Waits (bounded) for in_ready, then presents one command across a rising
  // edge, which becomes the accept edge. Returns just after that edge.
  task automatic start_op(input string tag, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check({tag, " in_ready timeout"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    // Operands only matter at the accept edge.
    in_a = 8'($urandom);
    in_b = 8'($urandom);
  endtask

  // Returns edge number (relative to T) at which out_valid is first high; 0 on timeout.
  task automatic wait_valid(output int lat);
    lat = 0;
    for (int e = 1; e <= 40 && lat == 0; e++) begin
      @(negedge clk);
      if (out_valid) lat = e;
    end
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, " busy after release"}, 32'(busy), 32'd0);
    @(negedge clk);
  endtask

  task automatic do_op(input string tag, input vec_t v);
    int lat;
    start_op(tag, v.op, v.a, v.b);
    wait_valid(lat);
    check({tag, " latency"}, 32'(lat), 32'(v.lat));
    check({tag, " res"},  32'(out_res),  32'(v.res));
    check({tag, " cout"}, 32'(out_cout), 32'(v.cout));
    check({tag, " ovf"},  32'(out_ovf),  32'(v.ovf));
    check({tag, " zero"}, 32'(out_zero), 32'(v.zero));
    check({tag, " err"},  32'(out_err),  32'(v.err));
    release_result(tag);
  endtask

  vec_t tbl[11];
  vec_t v;
  logic [15:0] held_res;
  int lat;
  int n_valid;

  initial begin
    // Expected values derived by hand from the operation definitions.
    //           op      a      b      res       cout  ovf   zero  err   lat
    tbl[0]  = '{OP_ADD, 8'h7F, 8'h01, 16'h0080, 1'b0, 1'b1, 1'b0, 1'b0, 2};
    tbl[1]  = '{OP_SUB, 8'h05, 8'h07, 16'h00FE, 1'b1, 1'b0, 1'b0, 1'b0, 2};
    tbl[2]  = '{OP_SUB, 8'h33, 8'h33, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 2};
    tbl[3]  = '{OP_MUL, 8'hFF, 8'hFF, 16'hFE01, 1'b1, 1'b0, 1'b0, 1'b0, 9};
    tbl[4]  = '{OP_MUL, 8'h00, 8'h5A, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 9};
    tbl[5]  = '{OP_DIV, 8'hC8, 8'h07, 16'h041C, 1'b0, 1'b0, 1'b0, 1'b0, 9};
    tbl[6]  = '{OP_DIV, 8'h55, 8'h00, 16'h55FF, 1'b0, 1'b0, 1'b0, 1'b1, 2};
    tbl[7]  = '{OP_MUL, 8'h0D, 8'h0B, 16'h008F, 1'b0, 1'b0, 1'b0, 1'b0, 9};
    tbl[8]  = '{OP_ADD, 8'hFF, 8'h01, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 2};
    tbl[9]  = '{OP_DIV, 8'h05, 8'h09, 16'h0500, 1'b0, 1'b0, 1'b1, 1'b0, 9};
    tbl[10] = '{OP_SUB, 8'h80, 8'h01, 16'h007F, 1'b0, 1'b1, 1'b0, 1'b0, 2};

    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset busy",      32'(busy),      32'd0);
    check("reset out_res",   32'(out_res),   32'd0);
    check("reset alu_a",     32'(alu_a),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 11; i++) do_op($sformatf("vec%0d", i), tbl[i]);

    // Backpressure: result and flags hold, no new command taken.
    start_op("bp", OP_MUL, 8'h12, 8'h34);
    wait_valid(lat);
    check("bp latency", 32'(lat), 32'd9);
    held_res = out_res;
    check("bp res", 32'(held_res), 32'h03A8);
    in_valid = 1'b1; in_op = OP_ADD; in_a = 8'h01; in_b = 8'h01;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("bp hold res %0d", k), 32'(out_res), 32'(held_res));
      check($sformatf("bp hold valid %0d", k), 32'(out_valid), 32'd1);
      check($sformatf("bp in_ready %0d", k), 32'(in_ready), 32'd0);
    end
    check("bp cout", 32'(out_cout), 32'd1);
    check("bp alu idle", 32'({alu_a, alu_b, alu_sub}), 32'd0);
    // in_valid stays high across the release edge: must not be taken there.
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp no same-cycle accept", 32'(busy), 32'd0);
    check("bp in_ready after release", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    if (busy) begin
      // A stray accept at the release edge would show up here too.
      wait_valid(lat);
      release_result("bp stray");
    end

    // Reset in the middle of a MUL aborts it with no result.
    start_op("rst", OP_MUL, 8'h0D, 8'h0B);
    repeat (3) @(negedge clk);
    check("rst busy mid-op", 32'(busy), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst busy",      32'(busy),      32'd0);
    check("rst in_ready",  32'(in_ready),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    n_valid = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_valid) n_valid++;
    end
    check("rst no partial result", 32'(n_valid), 32'd0);
    do_op("post-rst add", model(OP_ADD, 8'h10, 8'h22));

    // Randomized ops against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      logic [1:0] rop;
      logic [7:0] ra, rb;
      rop = 2'($urandom_range(0, 3));
      ra  = 8'($urandom);
      rb  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      v = model(rop, ra, rb);
      do_op($sformatf("rnd%0d op%0d %02h,%02h", i, rop, ra, rb), v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_alu_seq_ctrl
